// File: rtl/mips_datapath_memory_arbiter.sv
// Arbitrates a single byte-addressable data memory between the pipeline memory stage
// and a loader/debug host port, with a bounded host wait and one-cycle read returns.
module mips_datapath_memory_arbiter #(
    parameter int ADDR_L   = 64,
    parameter int ADDR_W   = $clog2(ADDR_L),
    parameter int HOST_MAX = 4
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              cpuReq,
    input  logic              cpuWren,
    input  logic [ADDR_W+1:0] cpuAddr,
    input  logic [31:0]       cpuData,
    input  logic [3:0]        cpuBytes,
    output logic              cpuGnt,
    output logic              cpuStall,
    output logic              cpuValid,
    output logic [31:0]       cpuOut,
    input  logic              hostReq,
    input  logic              hostWren,
    input  logic [ADDR_W+1:0] hostAddr,
    input  logic [31:0]       hostData,
    input  logic [3:0]        hostBytes,
    output logic              hostGnt,
    output logic              hostValid,
    output logic [31:0]       hostOut,
    output logic [ADDR_W+1:0] memAddr,
    output logic [31:0]       memData,
    output logic [3:0]        memBytes,
    output logic              memWren,
    input  logic [31:0]       memOut
);

    localparam logic [3:0] HOST_MAX_C = 4'(HOST_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CPU  = 2'd1,
        RD_HOST = 2'd2
    } state_t;

    state_t     stateR;
    state_t     nextStateS;
    logic [3:0] hostWaitR;
    logic [3:0] hostWaitNextS;

    // Grant decision: CPU has priority until the host has waited HOST_MAX cycles.
    always_comb begin
        hostGnt  = hostReq & (~cpuReq | (hostWaitR == HOST_MAX_C));
        cpuGnt   = cpuReq & ~hostGnt;
        cpuStall = cpuReq & ~cpuGnt;
    end

    // Memory port mux; writes are blocked while reset is held low.
    always_comb begin
        memAddr  = '0;
        memData  = 32'h0000_0000;
        memBytes = 4'b0000;
        memWren  = 1'b0;
        if (cpuGnt) begin
            memAddr  = cpuAddr;
            memData  = cpuData;
            memBytes = cpuBytes;
            memWren  = cpuWren & rstN;
        end else if (hostGnt) begin
            memAddr  = hostAddr;
            memData  = hostData;
            memBytes = hostBytes;
            memWren  = hostWren & rstN;
        end else begin
            memWren  = 1'b0;
        end
    end

    // Host wait counter next value (saturating, cleared by grant or idle host).
    always_comb begin
        hostWaitNextS = 4'd0;
        if (hostReq && !hostGnt) begin
            if (hostWaitR == HOST_MAX_C) begin
                hostWaitNextS = HOST_MAX_C;
            end else begin
                hostWaitNextS = hostWaitR + 4'd1;
            end
        end else begin
            hostWaitNextS = 4'd0;
        end
    end

    // Read-return next state: remember who owns the data arriving next cycle.
    always_comb begin
        nextStateS = IDLE;
        if (cpuGnt && !cpuWren) begin
            nextStateS = RD_CPU;
        end else if (hostGnt && !hostWren) begin
            nextStateS = RD_HOST;
        end else begin
            nextStateS = IDLE;
        end
    end

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            stateR    <= IDLE;
            hostWaitR <= 4'd0;
        end else begin
            stateR    <= nextStateS;
            hostWaitR <= hostWaitNextS;
        end
    end

    // Return outputs; a pending return is dropped in any cycle reset is low.
    always_comb begin
        cpuValid  = 1'b0;
        hostValid = 1'b0;
        cpuOut    = 32'h0000_0000;
        hostOut   = 32'h0000_0000;
        case (stateR)
            RD_CPU: begin
                cpuValid = rstN;
                cpuOut   = rstN ? memOut : 32'h0000_0000;
            end
            RD_HOST: begin
                hostValid = rstN;
                hostOut   = rstN ? memOut : 32'h0000_0000;
            end
            default: begin
                cpuValid  = 1'b0;
                hostValid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_datapath_memory_arbiter.sv
// Directed table-driven bench for the memory arbiter with a one-cycle-latency memory model.
module tb_mips_datapath_memory_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cpuReq, cpuWren, hostReq, hostWren;
    logic [7:0]  cpuAddr, hostAddr, memAddr;
    logic [31:0] cpuData, hostData, memData, cpuOut, hostOut;
    logic [31:0] memOut = 32'h0;
    logic [3:0]  cpuBytes, hostBytes, memBytes;
    logic        cpuGnt, cpuStall, cpuValid, hostGnt, hostValid, memWren;

    int nCmp = 0;
    int nBad = 0;
    logic [31:0] mem [0:63];

    mips_datapath_memory_arbiter dut (
        .clk(clk), .rstN(rstN),
        .cpuReq(cpuReq), .cpuWren(cpuWren), .cpuAddr(cpuAddr), .cpuData(cpuData),
        .cpuBytes(cpuBytes), .cpuGnt(cpuGnt), .cpuStall(cpuStall), .cpuValid(cpuValid),
        .cpuOut(cpuOut),
        .hostReq(hostReq), .hostWren(hostWren), .hostAddr(hostAddr), .hostData(hostData),
        .hostBytes(hostBytes), .hostGnt(hostGnt), .hostValid(hostValid), .hostOut(hostOut),
        .memAddr(memAddr), .memData(memData), .memBytes(memBytes), .memWren(memWren),
        .memOut(memOut)
    );

    always #5 clk = ~clk;

    // Memory model: registered read of the old word, byte-enabled write.
    always @(posedge clk) begin
        memOut <= mem[memAddr[7:2]];
        if (memWren) begin
            for (int b = 0; b < 4; b++) begin
                if (memBytes[b]) mem[memAddr[7:2]][8*b +: 8] <= memData[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic cReq; logic cWren; logic [7:0] cAddr; logic [31:0] cData; logic [3:0] cBytes;
        logic hReq; logic hWren; logic [7:0] hAddr; logic [31:0] hData; logic [3:0] hBytes;
        logic eCG; logic eHG; logic eSt; logic eMW; logic [7:0] eMA; logic [31:0] eMD; logic [3:0] eMB;
        logic eCV; logic eHV; logic [31:0] eOut;
    } vec_t;

    vec_t vecs [0:16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [31:0] cd,
                         input logic hr, input logic hw, input logic [7:0] ha, input logic [31:0] hd,
                         input logic [3:0] hb);
        cpuReq = cr; cpuWren = cw; cpuAddr = ca; cpuData = cd; cpuBytes = 4'hF;
        hostReq = hr; hostWren = hw; hostAddr = ha; hostData = hd; hostBytes = hb;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'hA5A5_0000;
        mem[2] = 32'hDEAD_BEEF;
        mem[4] = 32'h0BAD_F00D;

        // Fields: cpu req/wren/addr/data/bytes | host req/wren/addr/data/bytes |
        //         exp cpuGnt hostGnt cpuStall memWren memAddr memData memBytes | exp cpuValid hostValid data
        vecs[0]  = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,8'h08,32'h0,4'hF, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,1'b0,1'b0,8'h08,32'h0,4'hF, 1'b0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,32'hDEAD_BEEF};
        vecs[3]  = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b1,8'h04,32'h1234_5678,4'b0011, 1'b0,1'b1,1'b0,1'b1,8'h04,32'h1234_5678,4'b0011, 1'b0,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,32'h0};
        vecs[5]  = '{1'b1,1'b0,8'h00,32'h0,4'hF, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,1'b0,1'b0,8'h00,32'h0,4'hF, 1'b0,1'b0,32'h0};
        vecs[6]  = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,8'h10,32'h0,4'hF, 1'b0,1'b1,1'b0,1'b0,8'h10,32'h0,4'hF, 1'b1,1'b0,32'hA5A5_0000};
        vecs[7]  = '{1'b1,1'b0,8'h00,32'h0,4'hF, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,1'b0,1'b0,8'h00,32'h0,4'hF, 1'b0,1'b1,32'h0BAD_F00D};
        vecs[8]  = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,8'h10,32'h0,4'hF, 1'b0,1'b1,1'b0,1'b0,8'h10,32'h0,4'hF, 1'b1,1'b0,32'hA5A5_0000};
        vecs[9]  = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b1,32'h0BAD_F00D};
        vecs[10] = '{1'b1,1'b1,8'h0C,32'hCAFE_F00D,4'hF, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,1'b0,1'b1,8'h0C,32'hCAFE_F00D,4'hF, 1'b0,1'b0,32'h0};
        vecs[11] = '{1'b1,1'b0,8'h0C,32'h0,4'hF, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,1'b0,1'b0,8'h0C,32'h0,4'hF, 1'b0,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,32'hCAFE_F00D};
        vecs[13] = '{1'b1,1'b0,8'h08,32'h0,4'hF, 1'b1,1'b0,8'h04,32'h0,4'hF, 1'b1,1'b0,1'b0,1'b0,8'h08,32'h0,4'hF, 1'b0,1'b0,32'h0};
        vecs[14] = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,32'hDEAD_BEEF};
        vecs[15] = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b1,1'b0,8'h04,32'h0,4'hF, 1'b0,1'b1,1'b0,1'b0,8'h04,32'h0,4'hF, 1'b0,1'b0,32'h0};
        vecs[16] = '{1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,8'h00,32'h0,4'h0, 1'b0,1'b1,32'h0000_5678};

        // Reset: outputs idle once reset has been sampled
        rstN = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst cpuValid", 32'(cpuValid), 32'h0);
        chk("rst hostValid", 32'(hostValid), 32'h0);
        chk("rst cpuOut", cpuOut, 32'h0);
        chk("rst hostOut", hostOut, 32'h0);
        next_cycle();
        rstN = 1'b1;

        // Table vectors: one per cycle, combinational checks plus returns from the prior cycle
        for (int i = 0; i <= 16; i++) begin
            next_cycle();
            cpuReq = vecs[i].cReq; cpuWren = vecs[i].cWren; cpuAddr = vecs[i].cAddr;
            cpuData = vecs[i].cData; cpuBytes = vecs[i].cBytes;
            hostReq = vecs[i].hReq; hostWren = vecs[i].hWren; hostAddr = vecs[i].hAddr;
            hostData = vecs[i].hData; hostBytes = vecs[i].hBytes;
            @(negedge clk);
            chk($sformatf("v%0d cpuGnt", i), 32'(cpuGnt), 32'(vecs[i].eCG));
            chk($sformatf("v%0d hostGnt", i), 32'(hostGnt), 32'(vecs[i].eHG));
            chk($sformatf("v%0d cpuStall", i), 32'(cpuStall), 32'(vecs[i].eSt));
            chk($sformatf("v%0d memWren", i), 32'(memWren), 32'(vecs[i].eMW));
            chk($sformatf("v%0d memAddr", i), 32'(memAddr), 32'(vecs[i].eMA));
            chk($sformatf("v%0d memData", i), memData, vecs[i].eMD);
            chk($sformatf("v%0d memBytes", i), 32'(memBytes), 32'(vecs[i].eMB));
            chk($sformatf("v%0d cpuValid", i), 32'(cpuValid), 32'(vecs[i].eCV));
            chk($sformatf("v%0d hostValid", i), 32'(hostValid), 32'(vecs[i].eHV));
            chk($sformatf("v%0d cpuOut", i), cpuOut, vecs[i].eCV ? vecs[i].eOut : 32'h0);
            chk($sformatf("v%0d hostOut", i), hostOut, vecs[i].eHV ? vecs[i].eOut : 32'h0);
        end

        // Starvation guard: both requesting, host forced in every fifth cycle
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            drive(1'b1, 1'b0, 8'h08, 32'h0, 1'b1, 1'b0, 8'h04, 32'h0, 4'hF);
            @(negedge clk);
            chk($sformatf("fair%0d cpuGnt", k), 32'(cpuGnt), 32'((k % 5) != 4));
            chk($sformatf("fair%0d hostGnt", k), 32'(hostGnt), 32'((k % 5) == 4));
            chk($sformatf("fair%0d cpuStall", k), 32'(cpuStall), 32'((k % 5) == 4));
            if (k > 0) begin
                chk($sformatf("fair%0d cpuValid", k), 32'(cpuValid), 32'(((k - 1) % 5) != 4));
                chk($sformatf("fair%0d hostValid", k), 32'(hostValid), 32'(((k - 1) % 5) == 4));
                chk($sformatf("fair%0d data", k), cpuOut | hostOut,
                    (((k - 1) % 5) == 4) ? 32'h0000_5678 : 32'hDEAD_BEEF);
            end
        end

        // Reset right after a granted host read drops the return and blocks writes
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h10, 32'h0, 4'hF);
        @(negedge clk);
        chk("rr hostGnt", 32'(hostGnt), 32'h1);
        next_cycle();
        rstN = 1'b0;
        drive(1'b1, 1'b1, 8'h0C, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        chk("rr hostValid", 32'(hostValid), 32'h0);
        chk("rr hostOut", hostOut, 32'h0);
        chk("rr cpuGnt in reset", 32'(cpuGnt), 32'h1);
        chk("rr memAddr in reset", 32'(memAddr), 32'h0C);
        chk("rr memWren in reset", 32'(memWren), 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        next_cycle();
        rstN = 1'b1;
        drive(1'b1, 1'b0, 8'h08, 32'h0, 1'b1, 1'b0, 8'h04, 32'h0, 4'hF);
        @(negedge clk);
        chk("post cpuGnt", 32'(cpuGnt), 32'h1);
        chk("post hostGnt", 32'(hostGnt), 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 8'h0C, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        chk("post cpuValid", 32'(cpuValid), 32'h1);
        chk("post cpuOut", cpuOut, 32'hDEAD_BEEF);
        chk("post hostValid", 32'(hostValid), 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        @(negedge clk);
        chk("post blocked write", cpuOut, 32'hCAFE_F00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/mips_datapath_memory_arbiter.md
MIPS_DATAPATH_MEMORY_ARBITER -- requirements
Module: Mips_Datapath_Memory_arbiter

Interface
REQ-001 Parameter ADDR_L, default 64, SHALL set the data memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default log2(ADDR_L), SHALL set the word-address width; byte addresses are ADDR_W+2 bits.
REQ-003 Parameter HOST_MAX, default 4, legal range 1..15, SHALL set the host wait cycles before forced host grant.
REQ-004 Ports SHALL be:
- ctrl (clock field)  in  1  sole clock; all state updates on rising edge.
- ctrl (reset field)  in  1  reset; synchronous, active-low.
- cpuReq / cpuWren  in  1 / 1  pipeline memory-stage request / write.
- cpuAddr / cpuData / cpuBytes  in  ADDR_W+2 / 32 / 4  byte address, store data, byte enables.
- cpuGnt / cpuStall / cpuValid  out  1 / 1 / 1  grant, pipeline stall, read data valid.
- cpuOut  out  32  read data.
- hostReq / hostWren / hostAddr / hostData / hostBytes  in  1 / 1 / ADDR_W+2 / 32 / 4  loader/debug port request.
- hostGnt / hostValid  out  1 / 1; hostOut  out  32.
- memAddr / memData / memBytes / memWren  out  ADDR_W+2 / 32 / 4 / 1  to byte-addressable memory.
- memOut  in  32  memory read data, valid one cycle after address presented.

Function
REQ-005 Grants SHALL be combinational in the request cycle: hostGnt = hostReq & (~cpuReq | hostWait==HOST_MAX); cpuGnt = cpuReq & ~hostGnt.
REQ-006 cpuGnt and hostGnt SHALL never be high in the same cycle.
REQ-007 cpuStall SHALL equal cpuReq & ~cpuGnt.
REQ-008 Memory ports SHALL carry the granted requester's addr/data/bytes/wren; with no grant, memWren=0, memBytes=0, memAddr=0, memData=0.
REQ-009 hostWait (4-bit register) SHALL increment when hostReq & ~hostGnt, saturate at HOST_MAX, clear to 0 when hostGnt or ~hostReq.
REQ-010 Read-return FSM states: IDLE, RD_CPU, RD_HOST; next state RD_CPU on granted CPU read, RD_HOST on granted host read, else IDLE; evaluated every cycle.
REQ-011 cpuValid SHALL be 1 exactly in state RD_CPU, hostValid exactly in RD_HOST: one-cycle latency, one pulse per granted read.
REQ-012 cpuOut/hostOut SHALL equal memOut while the respective valid is 1, else 0.
REQ-013 Granted writes SHALL produce no valid pulse; next state IDLE.
REQ-014 Back-to-back grants to alternating requesters SHALL be supported with no idle cycle; returns remain in grant order.
REQ-015 A requester dropping req after grant SHALL still receive its pending valid pulse.
REQ-016 Forced host grant SHALL last exactly one cycle (hostWait clears), after which CPU priority resumes.

Reset
REQ-017 With reset low at a rising edge: state=IDLE, hostWait=0; from the next cycle cpuValid=hostValid=0, cpuOut=hostOut=0.
REQ-018 Grants and memory-port outputs SHALL remain combinational on req during reset but memWren SHALL be forced 0 while reset is low.
REQ-019 Reset asserted the cycle after a granted read SHALL suppress that read's valid pulse.

Verification
REQ-020 CPU-only read, addr 0x08 (memory holds 0xDEADBEEF) -> cpuGnt=1, cpuStall=0 same cycle; next cycle cpuValid=1, cpuOut=0xDEADBEEF, hostValid=0.
REQ-021 Host write addr 0x04 data 0x12345678 bytes 4'b0011, cpuReq=0 -> hostGnt=1, memWren=1, memBytes=4'b0011; no valid pulse next cycle.
REQ-022 cpuReq and hostReq held high continuously, HOST_MAX=4 -> CPU granted 4 cycles (cpuStall=0), host granted cycle 5, pattern repeats every 5 cycles.
REQ-023 Alternating CPU read addr 0x00 and host read addr 0x10 on consecutive cycles -> valid pulses alternate cpuValid/hostValid one cycle later with correct data, never both high.
REQ-024 Host read granted at cycle N, reset low at cycle N+1 edge -> hostValid=0 at N+1, hostWait=0, state IDLE; normal CPU read after reset release returns data in one cycle.
